poke_battle_ctrl: RTL and testbench

Turn-based battle sequencer for one player Pokémon against one enemy. It loads both stat sets, accepts one player move per round and applies player and enemy damage with type advantage. It awards XP and a level-up on victory, and publishes updated player/enemy stats with a one-cycle write strobe. It sits between the game-logic/input layer and the Pokémon stat registers, and is the only writer of battle-time stat updates.

---
 rtl/poke_pkg.sv | 37 +++
 rtl/poke_damage_calc.sv | 30 +++
 rtl/poke_battle_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_poke_battle_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poke_pkg.sv
// Shared battle types: FSM state encoding, type-chart size and the
// super-effective test used by the damage calculator.
package poke_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        WAIT_MOVE,
        P_ATTACK,
        CHECK_E,
        E_ATTACK,
        CHECK_P,
        AWARD,
        LEVEL,
        WRITE,
        DONE
    } battle_state_t;

    // Types 0..NUM_TYPES-1 form a cycle where each type beats the next one.
    // Anything at or above NUM_TYPES is neutral against everything.
    localparam logic [2:0] NUM_TYPES = 3'd5;

    function automatic logic is_super_effective(
        input logic [2:0] atk_type,
        input logic [2:0] def_type
    );
        logic [2:0] target;
        if (atk_type == NUM_TYPES - 3'd1) begin
            target = 3'd0;
        end else begin
            target = atk_type + 3'd1;
        end
        return (atk_type < NUM_TYPES) && (def_type < NUM_TYPES) &&
               (def_type == target);
    endfunction

endpackage

// File: rtl/poke_damage_calc.sv
// Combinational damage for one hit: attacker stats against defender stats,
// returning the damage dealt and the defender's remaining HP.
module poke_damage_calc
    import poke_pkg::*;
#(
    parameter logic [3:0] TYPE_BONUS = 4'd2
) (
    input  logic [3:0] attack,
    input  logic [3:0] defense,
    input  logic [2:0] atk_type,
    input  logic [2:0] def_type,
    input  logic [5:0] hp,
    output logic [5:0] dmg,
    output logic [5:0] hp_new
);

    logic              super_eff;
    logic [5:0]        bonus;
    logic signed [5:0] raw;

    // raw fits in signed 6 bits (-15..30); a non-positive hit still deals 1
    always_comb begin
        super_eff = is_super_effective(atk_type, def_type);
        bonus     = super_eff ? {2'b00, TYPE_BONUS} : 6'd0;
        raw       = $signed({2'b00, attack} + bonus - {2'b00, defense});
        dmg       = (raw <= 6'sd0) ? 6'd1 : $unsigned(raw);
        hp_new    = (hp > dmg) ? (hp - dmg) : 6'd0;
    end

endmodule

// File: rtl/poke_battle_ctrl.sv
// Turn-based battle sequencer: loads both stat sets, runs one round per
// accepted move, awards XP/level on a win and publishes stats on a strobe.
module poke_battle_ctrl
    import poke_pkg::*;
#(
    parameter logic [7:0] XP_PER_WIN = 8'd40,
    parameter logic [7:0] LEVEL_XP   = 8'd100,
    parameter logic [3:0] TYPE_BONUS = 4'd2,
    parameter logic [3:0] MAX_LEVEL  = 4'd15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [2:0] p_type_id,
    input  logic [2:0] e_type_id,
    input  logic [3:0] p_level,
    input  logic [7:0] p_xp,
    input  logic [5:0] p_hp,
    input  logic [5:0] e_hp,
    input  logic [3:0] p_attack,
    input  logic [3:0] e_attack,
    input  logic [3:0] p_defense,
    input  logic [3:0] e_defense,
    input  logic       move_valid,
    output logic       move_ready,
    output logic [5:0] p_hp_out,
    output logic [5:0] e_hp_out,
    output logic [7:0] p_xp_out,
    output logic [3:0] p_level_out,
    output logic [3:0] p_attack_out,
    output logic [3:0] p_defense_out,
    output logic       stats_we,
    output logic       busy,
    output logic       done,
    output logic       player_won
);

    battle_state_t state_reg, state_next;

    // working copy of the battle
    logic [2:0] p_type_reg,  p_type_next;
    logic [2:0] e_type_reg,  e_type_next;
    logic [3:0] p_level_reg, p_level_next;
    logic [7:0] p_xp_reg,    p_xp_next;
    logic [5:0] p_hp_reg,    p_hp_next;
    logic [5:0] e_hp_reg,    e_hp_next;
    logic [3:0] p_atk_reg,   p_atk_next;
    logic [3:0] p_def_reg,   p_def_next;
    logic [3:0] e_atk_reg,   e_atk_next;
    logic [3:0] e_def_reg,   e_def_next;
    logic       lethal_reg,  lethal_next;
    logic       over_reg,    over_next;
    logic       won_reg,     won_next;

    // published copy, only changes on the stats_we cycle
    logic [5:0] p_hp_out_reg;
    logic [5:0] e_hp_out_reg;
    logic [7:0] p_xp_out_reg;
    logic [3:0] p_level_out_reg;
    logic [3:0] p_attack_out_reg;
    logic [3:0] p_defense_out_reg;
    logic       stats_we_reg;
    logic       done_reg;
    logic       player_won_reg;

    // shared damage calculator, attacker chosen by state
    logic [3:0] calc_atk;
    logic [3:0] calc_def;
    logic [2:0] calc_atk_type;
    logic [2:0] calc_def_type;
    logic [5:0] calc_hp;
    logic [5:0] calc_dmg;
    logic [5:0] calc_hp_new;

    // XP after a win, clamped at 255
    logic [8:0] xp_sum;
    logic [7:0] xp_award;

    // level-up bumps attack [0] and defense [1], each clamped at 15
    logic [3:0] lvl_stat_cur [2];
    logic [3:0] lvl_stat_inc [2];

    assign lvl_stat_cur[0] = p_atk_reg;
    assign lvl_stat_cur[1] = p_def_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat_inc
            assign lvl_stat_inc[gi] = (lvl_stat_cur[gi] == 4'hF) ? 4'hF
                                                                 : lvl_stat_cur[gi] + 4'd1;
        end
    endgenerate

    assign xp_sum   = {1'b0, p_xp_reg} + {1'b0, XP_PER_WIN};
    assign xp_award = xp_sum[8] ? 8'hFF : xp_sum[7:0];

    // enemy hits the player in E_ATTACK; every other state routes player -> enemy
    always_comb begin
        if (state_reg == E_ATTACK) begin
            calc_atk      = e_atk_reg;
            calc_def      = p_def_reg;
            calc_atk_type = e_type_reg;
            calc_def_type = p_type_reg;
            calc_hp       = p_hp_reg;
        end else begin
            calc_atk      = p_atk_reg;
            calc_def      = e_def_reg;
            calc_atk_type = p_type_reg;
            calc_def_type = e_type_reg;
            calc_hp       = e_hp_reg;
        end
    end

    poke_damage_calc #(
        .TYPE_BONUS (TYPE_BONUS)
    ) u_damage (
        .attack   (calc_atk),
        .defense  (calc_def),
        .atk_type (calc_atk_type),
        .def_type (calc_def_type),
        .hp       (calc_hp),
        .dmg      (calc_dmg),
        .hp_new   (calc_hp_new)
    );

    // state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next state plus the state-decoded handshake/status outputs
    always_comb begin
        state_next = state_reg;
        move_ready = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (p_hp_reg == 6'd0) begin
                    state_next = WRITE;
                end else if (e_hp_reg == 6'd0) begin
                    state_next = AWARD;
                end else begin
                    state_next = WAIT_MOVE;
                end
            end
            WAIT_MOVE: begin
                move_ready = 1'b1;
                if (move_valid) begin
                    state_next = P_ATTACK;
                end
            end
            P_ATTACK: state_next = CHECK_E;
            CHECK_E:  state_next = lethal_reg ? AWARD : E_ATTACK;
            E_ATTACK: state_next = CHECK_P;
            CHECK_P:  state_next = WRITE;
            AWARD:    state_next = LEVEL;
            LEVEL:    state_next = WRITE;
            WRITE:    state_next = over_reg ? DONE : WAIT_MOVE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // working-register updates for the current state
    always_comb begin
        p_type_next  = p_type_reg;
        e_type_next  = e_type_reg;
        p_level_next = p_level_reg;
        p_xp_next    = p_xp_reg;
        p_hp_next    = p_hp_reg;
        e_hp_next    = e_hp_reg;
        p_atk_next   = p_atk_reg;
        p_def_next   = p_def_reg;
        e_atk_next   = e_atk_reg;
        e_def_next   = e_def_reg;
        lethal_next  = lethal_reg;
        over_next    = over_reg;
        won_next     = won_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    p_type_next  = p_type_id;
                    e_type_next  = e_type_id;
                    p_level_next = p_level;
                    p_xp_next    = p_xp;
                    p_hp_next    = p_hp;
                    e_hp_next    = e_hp;
                    p_atk_next   = p_attack;
                    p_def_next   = p_defense;
                    e_atk_next   = e_attack;
                    e_def_next   = e_defense;
                    lethal_next  = 1'b0;
                    over_next    = 1'b0;
                    won_next     = 1'b0;
                end
            end
            LOAD: begin
                // player arrives fainted: publish once and report a loss
                if (p_hp_reg == 6'd0) begin
                    over_next = 1'b1;
                end
            end
            P_ATTACK: begin
                e_hp_next   = calc_hp_new;
                lethal_next = (calc_dmg >= calc_hp);
            end
            E_ATTACK: begin
                p_hp_next   = calc_hp_new;
                lethal_next = (calc_dmg >= calc_hp);
            end
            CHECK_P: begin
                if (lethal_reg) begin
                    over_next = 1'b1;
                end
            end
            AWARD: begin
                p_xp_next = xp_award;
            end
            LEVEL: begin
                // reached only once per battle, so at most one level-up
                if ((p_xp_reg >= LEVEL_XP) && (p_level_reg < MAX_LEVEL)) begin
                    p_level_next = p_level_reg + 4'd1;
                    p_xp_next    = p_xp_reg - LEVEL_XP;
                    p_atk_next   = lvl_stat_inc[0];
                    p_def_next   = lvl_stat_inc[1];
                end
                over_next = 1'b1;
                won_next  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // working registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            p_type_reg  <= '0;
            e_type_reg  <= '0;
            p_level_reg <= '0;
            p_xp_reg    <= '0;
            p_hp_reg    <= '0;
            e_hp_reg    <= '0;
            p_atk_reg   <= '0;
            p_def_reg   <= '0;
            e_atk_reg   <= '0;
            e_def_reg   <= '0;
            lethal_reg  <= 1'b0;
            over_reg    <= 1'b0;
            won_reg     <= 1'b0;
        end else begin
            p_type_reg  <= p_type_next;
            e_type_reg  <= e_type_next;
            p_level_reg <= p_level_next;
            p_xp_reg    <= p_xp_next;
            p_hp_reg    <= p_hp_next;
            e_hp_reg    <= e_hp_next;
            p_atk_reg   <= p_atk_next;
            p_def_reg   <= p_def_next;
            e_atk_reg   <= e_atk_next;
            e_def_reg   <= e_def_next;
            lethal_reg  <= lethal_next;
            over_reg    <= over_next;
            won_reg     <= won_next;
        end
    end

    // published stats and strobes; loaded on entry to WRITE/DONE from the
    // _next values so the strobe cycle already carries this cycle's update
    always_ff @(posedge Clk) begin
        if (Reset) begin
            p_hp_out_reg      <= '0;
            e_hp_out_reg      <= '0;
            p_xp_out_reg      <= '0;
            p_level_out_reg   <= '0;
            p_attack_out_reg  <= '0;
            p_defense_out_reg <= '0;
            stats_we_reg      <= 1'b0;
            done_reg          <= 1'b0;
            player_won_reg    <= 1'b0;
        end else begin
            stats_we_reg <= (state_next == WRITE);
            done_reg     <= (state_next == DONE);
            if (state_next == WRITE) begin
                p_hp_out_reg      <= p_hp_next;
                e_hp_out_reg      <= e_hp_next;
                p_xp_out_reg      <= p_xp_next;
                p_level_out_reg   <= p_level_next;
                p_attack_out_reg  <= p_atk_next;
                p_defense_out_reg <= p_def_next;
            end
            if (state_next == DONE) begin
                player_won_reg <= won_next;
            end else if ((state_reg == IDLE) && start) begin
                player_won_reg <= 1'b0;
            end
        end
    end

    assign p_hp_out      = p_hp_out_reg;
    assign e_hp_out      = e_hp_out_reg;
    assign p_xp_out      = p_xp_out_reg;
    assign p_level_out   = p_level_out_reg;
    assign p_attack_out  = p_attack_out_reg;
    assign p_defense_out = p_defense_out_reg;
    assign stats_we      = stats_we_reg;
    assign done          = done_reg;
    assign player_won    = player_won_reg;

endmodule

// File: tb/tb_poke_battle_ctrl.sv
// Scoreboard bench for poke_battle_ctrl: the driver runs whole battles
// against an arithmetic battle model and queues the expected stat writes and
// battle results; the monitor checks every stats_we / done the DUT shows.
module tb_poke_battle_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start;
    logic [2:0] p_type_id, e_type_id;
    logic [3:0] p_level;
    logic [7:0] p_xp;
    logic [5:0] p_hp, e_hp;
    logic [3:0] p_attack, e_attack, p_defense, e_defense;
    logic       move_valid;
    logic       move_ready;
    logic [5:0] p_hp_out, e_hp_out;
    logic [7:0] p_xp_out;
    logic [3:0] p_level_out, p_attack_out, p_defense_out;
    logic       stats_we, busy, done, player_won;

    poke_battle_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .start         (start),
        .p_type_id     (p_type_id),
        .e_type_id     (e_type_id),
        .p_level       (p_level),
        .p_xp          (p_xp),
        .p_hp          (p_hp),
        .e_hp          (e_hp),
        .p_attack      (p_attack),
        .e_attack      (e_attack),
        .p_defense     (p_defense),
        .e_defense     (e_defense),
        .move_valid    (move_valid),
        .move_ready    (move_ready),
        .p_hp_out      (p_hp_out),
        .e_hp_out      (e_hp_out),
        .p_xp_out      (p_xp_out),
        .p_level_out   (p_level_out),
        .p_attack_out  (p_attack_out),
        .p_defense_out (p_defense_out),
        .stats_we      (stats_we),
        .busy          (busy),
        .done          (done),
        .player_won    (player_won)
    );

    always #5 Clk = ~Clk;

    // number of rising edges so far; read on falling edges
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int php; int ehp; int xp; int lvl; int atk; int def; int cyc;
    } wr_exp_t;
    typedef struct {
        bit won; int cyc;
    } done_exp_t;
    typedef struct {
        int pt; int et; int lvl; int xp; int php; int ehp;
        int patk; int pdef; int eatk; int edef;
    } battle_t;

    wr_exp_t   wr_q[$];
    done_exp_t done_q[$];
    wr_exp_t   mon_w;
    done_exp_t mon_d;

    // ---------------- behavioural battle model ----------------
    function automatic int model_dmg(int atk, int at, int dt, int def);
        bit se;
        int raw;
        se  = (at < 5) && (dt < 5) && (dt == (at + 1) % 5);
        raw = atk + (se ? 2 : 0) - def;
        return (raw <= 0) ? 1 : raw;
    endfunction

    function automatic int after_hit(int hp, int dmg);
        return (hp > dmg) ? hp - dmg : 0;
    endfunction

    task automatic model_award(inout int xp, inout int lvl, inout int atk, inout int def);
        xp = (xp + 40 > 255) ? 255 : xp + 40;
        if (xp >= 100 && lvl < 15) begin
            lvl = lvl + 1;
            xp  = xp - 100;
            atk = (atk < 15) ? atk + 1 : 15;
            def = (def < 15) ? def + 1 : 15;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        if (!Reset) begin
            if (stats_we) begin
                tests++;
                if (wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected: stats_we at cycle %0d, none required", cyc);
                end else begin
                    mon_w = wr_q.pop_front();
                    if (int'(p_hp_out) != mon_w.php || int'(e_hp_out) != mon_w.ehp ||
                        int'(p_xp_out) != mon_w.xp || int'(p_level_out) != mon_w.lvl ||
                        int'(p_attack_out) != mon_w.atk || int'(p_defense_out) != mon_w.def ||
                        cyc != mon_w.cyc) begin
                        fails++;
                        $display("FAIL write: got php=%0d ehp=%0d xp=%0d lvl=%0d atk=%0d def=%0d cyc=%0d required php=%0d ehp=%0d xp=%0d lvl=%0d atk=%0d def=%0d cyc=%0d",
                                 p_hp_out, e_hp_out, p_xp_out, p_level_out, p_attack_out,
                                 p_defense_out, cyc, mon_w.php, mon_w.ehp, mon_w.xp,
                                 mon_w.lvl, mon_w.atk, mon_w.def, mon_w.cyc);
                    end else begin
                        $display("[TB] write cyc=%0d php=%0d ehp=%0d xp=%0d lvl=%0d atk=%0d def=%0d",
                                 cyc, p_hp_out, e_hp_out, p_xp_out, p_level_out,
                                 p_attack_out, p_defense_out);
                    end
                end
            end
            if (done) begin
                tests++;
                if (done_q.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: done at cycle %0d, none required", cyc);
                end else begin
                    mon_d = done_q.pop_front();
                    if (player_won != mon_d.won || cyc != mon_d.cyc) begin
                        fails++;
                        $display("FAIL done: got won=%0d cyc=%0d required won=%0d cyc=%0d",
                                 player_won, cyc, mon_d.won, mon_d.cyc);
                    end else begin
                        $display("[TB] done cyc=%0d won=%0d", cyc, player_won);
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic scramble_inputs();
        p_type_id = 3'($urandom);  e_type_id = 3'($urandom);
        p_level   = 4'($urandom);  p_xp      = 8'($urandom);
        p_hp      = 6'($urandom);  e_hp      = 6'($urandom);
        p_attack  = 4'($urandom);  e_attack  = 4'($urandom);
        p_defense = 4'($urandom);  e_defense = 4'($urandom);
    endtask

    task automatic apply_inputs(input battle_t b);
        p_type_id = 3'(b.pt);   e_type_id = 3'(b.et);
        p_level   = 4'(b.lvl);  p_xp      = 8'(b.xp);
        p_hp      = 6'(b.php);  e_hp      = 6'(b.ehp);
        p_attack  = 4'(b.patk); e_attack  = 4'(b.eatk);
        p_defense = 4'(b.pdef); e_defense = 4'(b.edef);
    endtask

    task automatic drain_and_check(input bit won);
        int t;
        t = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0) && t < 40) begin
            @(negedge Clk);
            t++;
        end
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d writes and %0d results still pending",
                     wr_q.size(), done_q.size());
            wr_q.delete();
            done_q.delete();
        end
        @(negedge Clk);
        tests++;
        if (player_won != won || busy != 1'b0) begin
            fails++;
            $display("FAIL idle_hold: got won=%0d busy=%0d required won=%0d busy=0",
                     player_won, busy, won);
        end
    endtask

    // Runs one battle to completion; called on a falling edge with DUT idle.
    task automatic run_battle(input battle_t b, input bit poke_start);
        int S, D, t, k, expect_ready;
        int php, ehp, xp, lvl, atk, def;
        bit over, won;
        php = b.php; ehp = b.ehp; xp = b.xp; lvl = b.lvl; atk = b.patk; def = b.pdef;
        over = 1'b0; won = 1'b0;
        apply_inputs(b);
        start = 1'b1;
        S = cyc;
        @(negedge Clk);
        start = 1'b0;
        scramble_inputs();
        if (php == 0) begin
            wr_q.push_back('{php, ehp, xp, lvl, atk, def, S + 2});
            done_q.push_back('{1'b0, S + 3});
            over = 1'b1;
        end else if (ehp == 0) begin
            model_award(xp, lvl, atk, def);
            wr_q.push_back('{php, ehp, xp, lvl, atk, def, S + 4});
            done_q.push_back('{1'b1, S + 5});
            over = 1'b1; won = 1'b1;
        end
        expect_ready = S + 2;
        while (!over) begin
            t = 0;
            while (!move_ready && t < 20) begin
                @(negedge Clk);
                t++;
            end
            tests++;
            if (!move_ready) begin
                fails++;
                $display("FAIL move_ready_timeout: got 0 after 20 cycles, required 1");
                break;
            end
            if (cyc != expect_ready || busy != 1'b1) begin
                fails++;
                $display("FAIL move_ready_timing: got cyc=%0d busy=%0d required cyc=%0d busy=1",
                         cyc, busy, expect_ready);
            end
            D = cyc;
            ehp = after_hit(ehp, model_dmg(atk, b.pt, b.et, b.edef));
            if (ehp == 0) begin
                model_award(xp, lvl, atk, def);
                wr_q.push_back('{php, ehp, xp, lvl, atk, def, D + 5});
                done_q.push_back('{1'b1, D + 6});
                over = 1'b1; won = 1'b1;
            end else begin
                php = after_hit(php, model_dmg(b.eatk, b.et, b.pt, def));
                wr_q.push_back('{php, ehp, xp, lvl, atk, def, D + 5});
                if (php == 0) begin
                    done_q.push_back('{1'b0, D + 6});
                    over = 1'b1;
                end
            end
            expect_ready = D + 6;
            move_valid = 1'b1;
            k = poke_start ? 2 + int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 3));
            for (int i = 0; i < k; i++) begin
                @(negedge Clk);
                if (i == 0 && poke_start) start = 1'b1;
                else start = 1'b0;
            end
            start = 1'b0;
            move_valid = 1'b0;
        end
        drain_and_check(won);
    endtask

    // Starts a battle, issues one move and resets while the enemy attacks.
    task automatic run_abort();
        battle_t b;
        int t, D;
        b = '{pt: 0, et: 2, lvl: 4, xp: 20, php: 60, ehp: 60,
              patk: 1, pdef: 15, eatk: 1, edef: 15};
        apply_inputs(b);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        t = 0;
        while (!move_ready && t < 20) begin
            @(negedge Clk);
            t++;
        end
        D = cyc;
        move_valid = 1'b1;
        @(negedge Clk);
        move_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        tests++;
        if (cyc != D + 3 || t >= 20) begin
            fails++;
            $display("FAIL abort_setup: got cyc=%0d required cyc=%0d with move_ready seen", cyc, D + 3);
        end
        Reset = 1'b1;
        @(negedge Clk);
        tests++;
        if ({move_ready, busy, done, stats_we, player_won, p_hp_out, e_hp_out, p_xp_out,
             p_level_out, p_attack_out, p_defense_out} != '0) begin
            fails++;
            $display("FAIL abort_reset: got rdy=%0d busy=%0d done=%0d we=%0d won=%0d php=%0d ehp=%0d xp=%0d lvl=%0d atk=%0d def=%0d required all 0",
                     move_ready, busy, done, stats_we, player_won, p_hp_out, e_hp_out,
                     p_xp_out, p_level_out, p_attack_out, p_defense_out);
        end
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        tests++;
        if (busy != 1'b0 || move_ready != 1'b0) begin
            fails++;
            $display("FAIL abort_idle: got busy=%0d move_ready=%0d required 0 0", busy, move_ready);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        battle_t b;
        Reset = 1'b1;
        start = 1'b0;
        move_valid = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge Clk);
        tests++;
        if ({move_ready, busy, done, stats_we, player_won, p_hp_out, e_hp_out, p_xp_out,
             p_level_out, p_attack_out, p_defense_out} != '0) begin
            fails++;
            $display("FAIL reset_state: outputs not all zero (busy=%0d we=%0d php=%0d)",
                     busy, stats_we, p_hp_out);
        end
        Reset = 1'b0;
        @(negedge Clk);

        // normal rounds, neutral types
        run_battle('{0, 2, 5, 0, 20, 30, 10, 5, 6, 4}, 1'b0);
        // super-effective player hit
        run_battle('{0, 1, 5, 0, 20, 30, 10, 5, 6, 4}, 1'b0);
        // out-of-cycle types stay neutral
        run_battle('{5, 7, 5, 0, 20, 30, 10, 5, 6, 4}, 1'b0);
        // win with level-up
        run_battle('{0, 2, 3, 70, 20, 5, 10, 5, 6, 4}, 1'b0);
        // minimum damage
        run_battle('{0, 2, 3, 0, 40, 3, 3, 5, 6, 12}, 1'b0);
        // XP saturation at max level
        run_battle('{0, 2, 15, 250, 20, 1, 10, 5, 6, 4}, 1'b0);
        // level-up with attack/defense already at ceiling
        run_battle('{1, 3, 14, 90, 20, 2, 15, 15, 6, 4}, 1'b0);
        // loss in one enemy hit
        run_battle('{0, 2, 3, 0, 1, 60, 10, 5, 15, 4}, 1'b0);
        // player already fainted / enemy already fainted
        run_battle('{0, 2, 3, 10, 0, 30, 10, 5, 6, 4}, 1'b0);
        run_battle('{0, 2, 3, 80, 20, 0, 10, 5, 6, 4}, 1'b0);
        // start pulses while busy must be ignored
        run_battle('{2, 3, 6, 30, 15, 12, 9, 6, 7, 5}, 1'b1);
        // reset during the enemy attack
        run_abort();

        for (int n = 0; n < 40; n++) begin
            b.pt   = int'($urandom_range(0, 7));
            b.et   = int'($urandom_range(0, 7));
            b.lvl  = int'($urandom_range(0, 15));
            b.xp   = int'($urandom_range(0, 255));
            b.php  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
            b.ehp  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
            b.patk = int'($urandom_range(0, 15));
            b.pdef = int'($urandom_range(0, 15));
            b.eatk = int'($urandom_range(0, 15));
            b.edef = int'($urandom_range(0, 15));
            run_battle(b, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global time limit
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "time limit");
    end

endmodule
